// File: rtl/prenorm_stage.sv
// Two-stage pre-normalisation pipeline: classifies two IEEE-754 singles, left-justifies
// denormal fractions with the upstream leading-one counts and unpacks sign/mantissa/exponent.
module prenorm_stage #(
    parameter int unsigned EXPW = 10,
    parameter int unsigned MANW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [4:0]      shifta,
    input  logic [4:0]      shiftb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sa,
    output logic            sb,
    output logic [MANW-1:0] ma,
    output logic [MANW-1:0] mb,
    output logic [EXPW-1:0] ea,
    output logic [EXPW-1:0] eb,
    output logic            zero_a,
    output logic            inf_a,
    output logic            nan_a,
    output logic            den_a,
    output logic            err_a,
    output logic            zero_b,
    output logic            inf_b,
    output logic            nan_b,
    output logic            den_b,
    output logic            err_b
);

    localparam int unsigned CW = 1 + MANW + EXPW + 5;

    logic          r_s1_valid;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [4:0]    r_sha;
    logic [4:0]    r_shb;
    logic          r_out_valid;
    logic [CW-1:0] r_out_a;
    logic [CW-1:0] r_out_b;
    logic          w_s2_free;
    logic          w_s1_free;
    logic [CW-1:0] w_cls_a;
    logic [CW-1:0] w_cls_b;

    // Result layout: {sign, mantissa, exponent, zero, inf, nan, den, err}
    function automatic logic [CW-1:0] classify(input logic [31:0] x, input logic [4:0] s);
        logic [7:0]      e;
        logic [22:0]     f;
        logic [MANW-1:0] m;
        logic [EXPW-1:0] ex;
        logic            z, i, n, d, er;
        e  = x[30:23];
        f  = x[22:0];
        m  = '0;
        ex = '0;
        z  = 1'b0;
        i  = 1'b0;
        n  = 1'b0;
        d  = 1'b0;
        er = 1'b0;
        if (e == 8'hFF) begin
            ex = {{(EXPW-8){1'b0}}, e};
            if (f != 23'd0) begin
                n = 1'b1;
                m = {1'b1, f};
            end else begin
                i = 1'b1;
                m = {1'b1, 23'd0};
            end
        end else if (e == 8'd0) begin
            if (f == 23'd0) begin
                z = 1'b1;
            end else begin
                d = 1'b1;
                // Out-of-range counts are flagged rather than yielding a bogus mantissa
                if (s != 5'd0 && s <= 5'd23) begin
                    m  = {1'b0, f} << s;
                    ex = EXPW'(1) - {{(EXPW-5){1'b0}}, s};
                end else begin
                    er = 1'b1;
                end
            end
        end else begin
            m  = {1'b1, f};
            ex = {{(EXPW-8){1'b0}}, e};
        end
        return {x[31], m, ex, z, i, n, d, er};
    endfunction

    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;
    assign in_ready  = w_s1_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sha      <= '0;
            r_shb      <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a   <= a;
                r_b   <= b;
                r_sha <= shifta;
                r_shb <= shiftb;
            end
        end
    end

    always_comb begin
        w_cls_a = classify(r_a, r_sha);
        w_cls_b = classify(r_b, r_shb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_a <= w_cls_a;
                r_out_b <= w_cls_b;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign {sa, ma, ea, zero_a, inf_a, nan_a, den_a, err_a} = r_out_a;
    assign {sb, mb, eb, zero_b, inf_b, nan_b, den_b, err_b} = r_out_b;

endmodule

// File: tb/tb_prenorm_stage.sv
// Self-checking bench for prenorm_stage: directed cases with hand-derived results, a
// reference model for randomized traffic, back-pressure stability and mid-stream reset.
module tb_prenorm_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shifta = '0;
    logic [4:0]  shiftb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sa, sb;
    logic [23:0] ma, mb;
    logic [9:0]  ea, eb;
    logic        zero_a, inf_a, nan_a, den_a, err_a;
    logic        zero_b, inf_b, nan_b, den_b, err_b;

    int          checks = 0;
    int          failures = 0;
    logic [79:0] q_exp[$];
    logic        acc, took, stall_prev = 1'b0;
    logic [79:0] snap;
    int          n_taken = 0;

    prenorm_stage #(.EXPW(10), .MANW(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .shifta(shifta), .shiftb(shiftb),
        .out_valid(out_valid), .out_ready(out_ready),
        .sa(sa), .sb(sb), .ma(ma), .mb(mb), .ea(ea), .eb(eb),
        .zero_a(zero_a), .inf_a(inf_a), .nan_a(nan_a), .den_a(den_a), .err_a(err_a),
        .zero_b(zero_b), .inf_b(inf_b), .nan_b(nan_b), .den_b(den_b), .err_b(err_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    function automatic logic [79:0] outvec();
        return {sa, ma, ea, zero_a, inf_a, nan_a, den_a, err_a,
                sb, mb, eb, zero_b, inf_b, nan_b, den_b, err_b};
    endfunction

    // Reference: arithmetic view of the classification rules
    function automatic logic [39:0] model(input logic [31:0] x, input int s);
        int     e, f, ex;
        longint m;
        logic   z, i, n, d, er;
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        m = 0; ex = 0; z = 0; i = 0; n = 0; d = 0; er = 0;
        if (e == 255) begin
            ex = 255;
            if (f != 0) begin n = 1; m = 64'd8388608 + f; end
            else begin i = 1; m = 64'd8388608; end
        end else if (e == 0) begin
            if (f == 0) z = 1;
            else begin
                d = 1;
                if (s >= 1 && s <= 23) begin
                    m  = (longint'(f) * (longint'(1) << s)) % (longint'(1) << 24);
                    ex = 1 - s;
                end else er = 1;
            end
        end else begin
            m  = 64'd8388608 + f;
            ex = e;
        end
        return {x[31], m[23:0], ex[9:0], z, i, n, d, er};
    endfunction

    function automatic int lead_shift(input logic [22:0] f);
        int p = 0;
        for (int k = 0; k < 23; k++) if (f[k]) p = k;
        return 23 - p;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        int          c;
        x = $urandom;
        c = $urandom_range(0, 5);
        if (c == 0) x[30:23] = 8'h00;
        if (c == 1) x[30:23] = 8'hFF;
        if (c == 2) x[22:0] = '0;
        if (c == 3) begin x[30:23] = 8'h00; x[22:0] = 23'(1) << $urandom_range(0, 22); end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, evaluate handshakes 1 time unit later
    task automatic cyc(input logic iv, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [4:0] s_a, input logic [4:0] s_b, input logic ordy,
                       input logic use_c, input logic [39:0] ca, input logic [39:0] cb);
        logic [79:0] e;
        @(negedge clk);
        in_valid = iv; a = ta; b = tb; shifta = s_a; shiftb = s_b; out_ready = ordy;
        #1;
        if (stall_prev) chk("stall_hold", {out_valid, outvec()}, {1'b1, snap});
        acc  = in_valid && in_ready;
        took = out_valid && out_ready;
        if (took) begin
            if (q_exp.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = q_exp.pop_front();
                chk("res_a", outvec()[79:40], e[79:40]);
                chk("res_b", outvec()[39:0], e[39:0]);
                n_taken++;
            end
        end
        if (acc) q_exp.push_back(use_c ? {ca, cb} : {model(a, int'(shifta)), model(b, int'(shiftb))});
        stall_prev = out_valid && !out_ready;
        snap = outvec();
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q_exp.size() != 0; k++) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("drain_left", q_exp.size(), 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  rsa, rsb;
        int          acc_cnt;
        logic        saw_block;

        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_outs", outvec(), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Normals, streamed
        cyc(1, 32'h3F80_0000, 32'hC000_0000, 5'd7, 5'd9, 1, 1,
            {1'b0, 24'h800000, 10'd127, 5'b00000}, {1'b1, 24'h800000, 10'd128, 5'b00000});
        chk("normal_acc", acc, 1);
        // Denormal extremes
        cyc(1, 32'h0000_0001, 32'h0040_0000, 5'd23, 5'd1, 1, 1,
            {1'b0, 24'h800000, 10'h3EA, 5'b00010}, {1'b0, 24'h800000, 10'd0, 5'b00010});
        // Specials
        cyc(1, 32'h7FC0_0001, 32'hFF80_0000, 5'd3, 5'd0, 1, 1,
            {1'b0, 24'hC00001, 10'd255, 5'b00100}, {1'b1, 24'h800000, 10'd255, 5'b01000});
        cyc(1, 32'h8000_0000, 32'h3F80_0000, 5'd31, 5'd0, 1, 1,
            {1'b1, 24'h0, 10'd0, 5'b10000}, {1'b0, 24'h800000, 10'd127, 5'b00000});
        // Inconsistent shift counts
        cyc(1, 32'h0000_0010, 32'h0000_0000, 5'd0, 5'd4, 1, 1,
            {1'b0, 24'h0, 10'd0, 5'b00011}, {1'b0, 24'h0, 10'd0, 5'b10000});
        cyc(1, 32'h0000_0010, 32'h0000_0000, 5'd25, 5'd4, 1, 1,
            {1'b0, 24'h0, 10'd0, 5'b00011}, {1'b0, 24'h0, 10'd0, 5'b10000});
        drain();

        // Back-pressure: out_ready low on cycles 3..7
        acc_cnt = 0;
        saw_block = 0;
        for (int c = 1; c <= 40 && (acc_cnt < 6 || q_exp.size() != 0); c++) begin
            ra = rand_op(); rb = rand_op();
            cyc(acc_cnt < 6, ra, rb, 5'(lead_shift(ra[22:0])), 5'(lead_shift(rb[22:0])),
                !(c >= 3 && c <= 7), 0, 0, 0);
            if (acc_cnt < 6 && !in_ready && !saw_block) begin
                saw_block = 1;
                chk("bp_accepts_before_block", acc_cnt, 2);
            end
            if (acc) acc_cnt++;
        end
        chk("bp_blocked", saw_block, 1);
        chk("bp_taken", n_taken, 12);
        drain();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            ra = rand_op(); rb = rand_op();
            rsa = ($urandom_range(0, 1) != 0) ? 5'(lead_shift(ra[22:0])) : 5'($urandom);
            rsb = ($urandom_range(0, 1) != 0) ? 5'(lead_shift(rb[22:0])) : 5'($urandom);
            cyc($urandom_range(0, 3) != 0, ra, rb, rsa, rsb, $urandom_range(0, 9) < 7, 0, 0, 0);
        end
        drain();

        // Reset with both stages full
        cyc(1, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h4080_0000, 32'h40A0_0000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_before_rst", {out_valid, in_ready}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_async", out_valid, 0);
        chk("rst_outs_async", outvec(), 0);
        q_exp.delete();
        stall_prev = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("post_rst_idle", {out_valid, in_ready}, 2'b01);
        cyc(1, 32'hBF80_0000, 32'h0000_0003, 0, 5'd22, 1, 1,
            {1'b1, 24'h800000, 10'd127, 5'b00000}, {1'b0, 24'hC00000, 10'h3EB, 5'b00010});
        chk("post_rst_acc", acc, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("lat_cycle1", out_valid, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("lat_cycle2", took, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prenorm_stage.md
Name: prenorm_stage

Overview:
- Two-operand pre-normalisation pipeline for the FIR single-precision datapath.
- Sits directly downstream of the leading-one shift-count logic (prenormshift), which takes the same a/b words and feeds this block its shifta/shiftb counts.
- Classifies each IEEE-754 operand, left-justifies denormal fractions using the supplied shift counts, and emits unpacked sign, mantissa and exponent plus class flags.
- Output goes to the multiplier/adder core through a valid/ready pipeline with full back-pressure.

Parameters:
- EXPW, 10, width of the signed, biased output exponent.
- MANW, 24, width of the output mantissa including the hidden bit; fixed by single precision.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b, shifta and shiftb are valid this cycle.
- in_ready  output  1  the block accepts input this cycle.
- a  input  32  IEEE-754 single operand A.
- b  input  32  IEEE-754 single operand B.
- shifta  input  5  leading-one shift count for a[22:0]; meaningful only when A is denormal.
- shiftb  input  5  leading-one shift count for b[22:0].
- out_valid  output  1  outputs hold a result.
- out_ready  input  1  downstream accepts the result this cycle.
- sa, sb  output  1 each  operand signs.
- ma, mb  output  MANW each  normalised mantissas; bit 23 is the leading one.
- ea, eb  output  EXPW each  biased exponents, signed two's complement.
- zero_a, inf_a, nan_a, den_a, err_a  output  1 each  class flags for A.
- zero_b, inf_b, nan_b, den_b, err_b  output  1 each  class flags for B.

Behaviour:
- Reset, asynchronous on rst_n low: both stage valid bits, out_valid and all data and flag outputs go to 0.
- Pipeline: two registered stages.
  - S1 captures a, b, shifta and shiftb on in_valid && in_ready.
  - S2 holds the computed outputs.
  - Latency is 2 cycles from accept to out_valid with no stall; throughput is 1 per cycle.
- Ready chain:
  - s2_free = !out_valid || out_ready.
  - s1_free = !s1_valid || s2_free.
  - in_ready = s1_free. This is combinational from out_ready; no bubble is needed for full throughput.
- Stall: while out_valid && !out_ready, all outputs stay stable. S1 holds its contents; if S1 is also full, in_ready = 0.
- Handshake rules: out_valid never drops without out_ready. Data is never duplicated or lost.
- Classification per operand, with e = x[30:23] and f = x[22:0]:
  - e == 255, f != 0: nan = 1, m = {1, f}, exp = 255.
  - e == 255, f == 0: inf = 1, m = 0x800000, exp = 255.
  - e == 0, f == 0: zero = 1, m = 0, exp = 0.
  - e == 0, f != 0, shift s in 1..23: den = 1, m = ({1'b0, f} << s)[23:0], exp = 1 - s, giving a range of 0 down to -22.
  - e == 0, f != 0, s == 0 or s > 23: den = 1, err = 1, m = 0, exp = 0. An inconsistent count from upstream must never produce a silently wrong mantissa.
  - Otherwise (normal): m = {1, f}, exp = e zero-extended.
  - Sign is x[31] in every class.
  - The shift input is ignored for every class other than denormal.
- Flags: at most one of zero/inf/nan/den is set per operand; err implies den.
- Simultaneous events:
  - An accept into S1 in the same cycle S1 moves to S2 is legal and required for full throughput.
  - An accept at S2 in the same cycle as the downstream take is likewise legal.
- Reset mid-operation clears in-flight data; nothing is emitted after rst_n deasserts until a new accept.

Test Plan:
- Normals: a=0x3F800000, b=0xC0000000, streamed with out_ready=1 -> 2 cycles later sa=0, ma=0x800000, ea=127; sb=1, mb=0x800000, eb=128; no flags set.
- Denormal extremes: a=0x00000001 with shifta=23, b=0x00400000 with shiftb=1 -> ma=0x800000, ea=-22 (0x3EA); mb=0x800000, eb=0; den_a=den_b=1.
- Specials: a=0x7FC00001, b=0xFF800000, then a=0x80000000 -> nan_a=1 with ma=0xC00001 and ea=255; inf_b=1, sb=1; then zero_a=1, sa=1, ma=0, ea=0.
- Bad count: a=0x00000010, shifta=0, then again with shifta=25 -> both results have err_a=1, den_a=1, ma=0, ea=0.
- Back-pressure: 6 back-to-back inputs with out_ready low for cycles 3-7 -> in_ready falls after 2 accepts; outputs stay stable while stalled; all 6 results arrive in order with none dropped or duplicated.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 and all outputs 0 immediately (asynchronous); after release, in_ready=1 and the first new input appears 2 cycles after accept.
